// File: rtl/board_io_pkg.sv
// Shared defaults and helpers for the board I/O conditioning block.
// Holds parameter defaults, synchroniser depth and counter-width helper.
package board_io_pkg;

    localparam int DefNumSw          = 4;
    localparam int DefNumBtn         = 4;
    localparam int DefNumLed         = 4;
    localparam int DefDebounceCycles = 50000;
    localparam int DefLampTestCycles = 25000000;

    localparam int SyncStages = 2;

    function automatic int cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/board_io_debounce.sv
// One debounced input channel: 2-flop synchroniser, stability counter,
// stable level and registered one-cycle rise/fall pulses.
module board_io_debounce
    import board_io_pkg::*;
#(
    parameter int DebounceCycles = DefDebounceCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CntW = cnt_width(DebounceCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  stable_q, stable_d;
    logic                  prev_q, prev_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  differ;

    always_comb begin
        sync_d   = {sync_q[SyncStages-2:0], pin_i};
        differ   = sync_q[SyncStages-1] ^ stable_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (differ) begin
            if (cnt_q == CntLast) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Pulses land one cycle after the stable level has moved.
        prev_d = stable_q;
        rise_d = stable_q & ~prev_q;
        fall_d = ~stable_q & prev_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/board_io_cond.sv
// Board switch/button conditioning plus registered LED drive.
// Optional post-reset lamp test enabled by BOARD_IO_LAMP_TEST_EN.
module board_io_cond
    import board_io_pkg::*;
#(
    parameter int NumSw          = DefNumSw,
    parameter int NumBtn         = DefNumBtn,
    parameter int NumLed         = DefNumLed,
    parameter int DebounceCycles = DefDebounceCycles,
    parameter int LampTestCycles = DefLampTestCycles
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_sys_ni,
    input  logic [NumSw-1:0]        sw_i,
    input  logic [NumBtn-1:0]       btn_i,
    output logic [NumSw+NumBtn-1:0] gp_o,
    output logic [NumBtn-1:0]       btn_rise_o,
    output logic [NumBtn-1:0]       btn_fall_o,
    input  logic [NumLed-1:0]       led_gp_i,
    output logic [NumLed-1:0]       led_o,
    output logic                    lamp_test_o
);

    localparam int NumCh = NumSw + NumBtn;

    logic [NumCh-1:0] raw, level, rise, fall;
    logic [2*NumSw-1:0] unused_sw_edge;

    assign raw = {sw_i, btn_i};

    for (genvar i = 0; i < NumCh; i++) begin : g_chan
        board_io_debounce #(
            .DebounceCycles(DebounceCycles)
        ) u_chan (
            .clk_i  (clk_sys_i),
            .rst_ni (rst_sys_ni),
            .pin_i  (raw[i]),
            .level_o(level[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    assign gp_o           = level;
    assign btn_rise_o     = rise[NumBtn-1:0];
    assign btn_fall_o     = fall[NumBtn-1:0];
    // Switches report levels only; their edge pulses have no consumer.
    assign unused_sw_edge = {rise[NumCh-1:NumBtn], fall[NumCh-1:NumBtn]};

    logic [NumLed-1:0] led_q, led_d;

`ifdef BOARD_IO_LAMP_TEST_EN
    localparam int LampW = cnt_width(LampTestCycles);
    localparam logic [LampW-1:0] LampLast = LampW'(LampTestCycles);

    logic [LampW-1:0] lamp_cnt_q, lamp_cnt_d;
    logic             lamp_q, lamp_d;

    always_comb begin
        lamp_cnt_d = lamp_cnt_q;
        lamp_d     = 1'b0;
        if (lamp_cnt_q != LampLast) begin
            lamp_cnt_d = lamp_cnt_q + 1'b1;
            lamp_d     = 1'b1;
        end
        led_d = lamp_d ? '1 : led_gp_i;
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            lamp_cnt_q <= '0;
            lamp_q     <= 1'b0;
        end else begin
            lamp_cnt_q <= lamp_cnt_d;
            lamp_q     <= lamp_d;
        end
    end

    assign lamp_test_o = lamp_q;
`else
    localparam int unused_lamp_cycles = LampTestCycles;

    always_comb begin
        led_d = led_gp_i;
    end

    assign lamp_test_o = 1'b0;
`endif

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: doc/board_io_cond.md
BOARD_IO_COND -- requirements
Module: board_io_cond

Interface
REQ-001 SHALL have parameter NumSw, default 4: number of slide-switch inputs, range 1..16.
REQ-002 SHALL have parameter NumBtn, default 4: number of push-button inputs, range 1..16.
REQ-003 SHALL have parameter NumLed, default 4: number of LED outputs, range 1..16.
REQ-004 SHALL have parameter DebounceCycles, default 50000: stable-cycle count, range 1..2^20.
REQ-005 SHALL have parameter LampTestCycles, default 25000000: post-reset lamp-test length, minimum 1.
REQ-006 SHALL have port clk_sys_i, input, 1 bit: the only clock.
REQ-007 SHALL have port rst_sys_ni, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port sw_i, input, NumSw bits: raw asynchronous switch pins.
REQ-009 SHALL have port btn_i, input, NumBtn bits: raw asynchronous button pins.
REQ-010 SHALL have port gp_o, output, NumSw+NumBtn bits: debounced levels packed as {sw, btn}.
REQ-011 SHALL have port btn_rise_o, output, NumBtn bits: one-cycle pulse per debounced 0->1 transition.
REQ-012 SHALL have port btn_fall_o, output, NumBtn bits: one-cycle pulse per debounced 1->0 transition.
REQ-013 SHALL have port led_gp_i, input, NumLed bits: LED request from the system GPO.
REQ-014 SHALL have port led_o, output, NumLed bits: registered LED pin drive.
REQ-015 SHALL have port lamp_test_o, output, 1 bit: high while the lamp test is active.

Function
REQ-016 Each input bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-017 Each channel SHALL hold a stable level and a counter of width clog2(DebounceCycles+1).
- Counter increments while the synchronised level differs from the stable level.
- Counter clears to 0 on any cycle where the two levels match.
REQ-018 When the counter equals DebounceCycles-1 and the levels still differ, the channel SHALL invert its stable level and clear the counter at the next edge.
REQ-019 A clean pin step SHALL reach gp_o exactly 2+DebounceCycles clock cycles after the first sampling edge.
REQ-020 A pin pulse or glitch lasting fewer than DebounceCycles synchronised cycles SHALL leave gp_o unchanged.
REQ-021 btn_rise_o or btn_fall_o SHALL be high in exactly the one cycle after the stable-level change; the two are never high together on one channel.
REQ-022 Channels SHALL be fully independent; simultaneous transitions on any set of channels SHALL each be reported in the same cycle.
REQ-023 led_o SHALL equal led_gp_i delayed by one register stage, except as modified by REQ-027.

Reset
REQ-024 Reset assertion SHALL asynchronously clear all of the following to 0, including mid-debounce, which discards any partial count:
- synchroniser flops, stable levels and counters;
- gp_o, btn_rise_o, btn_fall_o, led_o and lamp_test_o.
REQ-025 After reset release, no rise or fall pulse SHALL occur unless a pin differs from 0 for a full debounce interval.

Configuration
REQ-026 Macro BOARD_IO_LAMP_TEST_EN SHALL compile the lamp-test feature in or out.
REQ-027 With BOARD_IO_LAMP_TEST_EN defined, a counter SHALL run after reset release; behaviour:
- lamp_test_o=1 and led_o all ones for LampTestCycles cycles, starting at the first edge after release;
- then lamp_test_o=0 permanently and led_o follows REQ-023;
- led_gp_i is ignored during the test.
REQ-028 Without BOARD_IO_LAMP_TEST_EN, the lamp-test counter SHALL be absent and lamp_test_o SHALL be tied to 0.

Structure
REQ-029 Package board_io_pkg SHALL hold the following defaults, and nothing module-specific:
- default parameter constants;
- the synchroniser depth constant (2);
- the function computing counter width.
REQ-030 Sub-module board_io_debounce SHALL implement one channel (sync, counter, stable level, edge pulses) and be instantiated NumSw+NumBtn times in a generate loop.

Verification (bench: DebounceCycles=8, LampTestCycles=16)
REQ-031 btn_i[0] steps 0->1 and holds: gp_o[0] rises exactly 10 cycles later, and btn_rise_o[0] pulses for 1 cycle on the following cycle.
REQ-032 btn_i[1] pulses high for 5 cycles, then 0: gp_o[1], btn_rise_o[1] and btn_fall_o[1] stay 0 throughout.
REQ-033 sw_i=4'hF and btn_i=4'hF step together: gp_o=8'hFF in a single cycle, and all four btn_rise_o bits pulse together.
REQ-034 Reset is asserted 4 cycles into a debounce of btn_i[2]: outputs drop to 0 immediately, and after release the full 10-cycle latency restarts.
REQ-035 With BOARD_IO_LAMP_TEST_EN and led_gp_i=4'h5: led_o=4'hF and lamp_test_o=1 for 16 cycles, then led_o=4'h5 and lamp_test_o=0.
REQ-036 Without BOARD_IO_LAMP_TEST_EN and led_gp_i=4'hA: led_o=4'hA one cycle after reset release, and lamp_test_o stays 0.
